top_level: RTL and testbench
============================

Name: top_level

Overview:
- Self-contained hardwired accelerator with an internal 256-byte data memory. It runs three fixed programs in rotation, advancing one program per `req` pulse:
  - Program 1: Hamming(16,11) SECDED encode.
  - Program 2: SECDED decode and correct.
  - Program 3: 5-bit pattern count.
- Signals completion on `ack`.
- The testbench preloads and inspects memory hierarchically between programs.

Parameters:
- none. All addresses and counts are fixed.

Ports:
- `clk`    input   1  system clock, rising edge.
- `reset`  input   1  synchronous, active-high.
- `req`    input   1  one-cycle start pulse.
- `ack`    output  1  program done; high until the next `req` is accepted.

Behaviour:
- Memory:
  - Instance `data_mem1` contains array `core[0:255]`, 8 bits wide, reachable hierarchically.
  - Combinational read, write on the rising clock edge, one access per cycle.
  - Reset never clears memory.
- Reset:
  - `ack`=0, FSM=IDLE, program pointer=1, counters=0.
- Handshake:
  - `req` is sampled in IDLE.
  - The edge that samples `req`=1 clears `ack` and starts the program selected by the pointer.
  - On finish: `ack`=1 (registered), then return to IDLE and advance pointer 1→2→3→1.
  - `req` while busy is ignored.
  - Each program must finish within 300 cycles.
- Program 1 (encode), i=0..14:
  - Input d[11:1]: d[8:1]=`core[2i]`, d[11:9]=`core[2i+1][2:0]`.
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p16 = ^d ^ p8^p4^p2^p1
  - Word W = {d[11:5],p8,d[4:2],p4,d1,p2,p1,p16}.
  - Write `core[30+2i]`=W[7:0] and `core[31+2i]`=W[15:8].
- Program 2 (decode), i=0..14:
  - Input W = {`core[65+2i]`,`core[64+2i]`}; W[k] is Hamming position k for k=1..15, and W[0] is overall parity.
  - Syndrome S = XOR of k over all set W[k], k=1..15 (4 bits).
  - P = ^W[15:0].
  - Cases:
    - S=0, P=0: no error.
    - P=1: single error; flip W[S] (S=0 means W[0] flipped, data unaffected).
    - P=0, S≠0: double error; data left uncorrected, flag F=1.
  - Extract d = {W15..W9, W7,W6,W5, W3}.
  - Write `core[94+2i]`=d[8:1] and `core[95+2i]`={F,4'b0,d[11:9]}.
  - F=0 in all non-double cases.
- Program 3 (pattern count):
  - pat=`core[160][4:0]`. String is `core[128..159]`, where `core[128]` holds the most significant 8 bits of a 256-bit string.
  - `core[192]` = sum over 32 bytes of matches at byte slices [4:0],[5:1],[6:2],[7:3]. Maximum 128.
  - `core[193]` = number of bytes with at least one such match. Maximum 32.
  - `core[194]` = matches over all 252 5-bit windows of the 256-bit string, including windows that cross byte boundaries. Maximum 252.
  - Counters are 8 bits, cleared at program start.
  - Sequential byte processing is allowed, carrying the previous byte's low 4 bits to form crossing windows.
- Program 3 writes only 192..194; Program 1 only 30..59; Program 2 only 94..123.

Test Plan:
- Program 1 encode:
  - Stimulus: d=11'h000, 11'h001, 11'h7FF in slots 0..2.
  - Required: {`core[31]`,`core[30]`}=0x0000, {`core[33]`,`core[32]`}=0x000F, {`core[35]`,`core[34]`}=0xFFFF.
  - Required: `ack` rises within 300 cycles and is 0 on the cycle after `req` is sampled.
- Program 2 single-error correction:
  - Stimulus: inputs 0xFFDF (bit 5 flipped), 0x000E (p16 flipped), 0x000F (clean).
  - Required outputs: {0x07,0xFF}, {0x00,0x01}, {0x00,0x01}.
- Program 2 double error:
  - Stimulus: input 0xFDDF (bits 5 and 9 flipped).
  - Required: `core[95]`[7]=1.
- Program 3 uniform string:
  - Stimulus: pat=0, all bytes 0x00 → `core[192..194]`=128,32,252.
  - Stimulus: pat=0, all bytes 0xFF → 0,0,0.
- Program 3 byte placement:
  - Stimulus: pat=5'b11111, `core[128]`=0xF8, rest 0 → counts 1,1,1.
  - Stimulus: pat=5'b11111, `core[128]`=0x03, `core[129]`=0xE0, rest 0 → counts 0,0,1 (crossing only).
- Sequencing: four `req` pulses run Program 1, 2, 3, then 1 again. A `req` while busy is ignored. Reset mid-program leaves `ack`=0 and the pointer at Program 1.

Source files
------------

// File: rtl/top_level.sv
// Hardwired SECDED encode/decode and 5-bit pattern-count accelerator
// over a 256-byte single-port data memory; one program per req pulse.
module data_mem (
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);
    logic [7:0] core [0:255];

    always @(posedge clk) begin
        if (i_we) core[i_addr] <= i_wdata;
    end

    assign o_rdata = core[i_addr];
endmodule

module top_level (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic ack
);
    typedef enum logic [3:0] {
        S_IDLE, S_E0, S_E1, S_E2, S_E3,
        S_D0, S_D1, S_D2, S_D3,
        S_CP, S_CB, S_CW0, S_CW1, S_CW2, S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_prog;
    logic        r_ack;
    logic [4:0]  r_idx;
    logic [7:0]  r_lo, r_hi;
    logic [4:0]  r_pat;
    logic [3:0]  r_prev;
    logic [7:0]  r_c0, r_c1, r_c2;

    logic [7:0]  w_addr, w_wdata, w_rdata, w_i2;
    logic        w_we;
    logic [11:1] w_d;
    logic        w_p8, w_p4, w_p2, w_p1, w_p16;
    logic [15:0] w_enc, w_cw, w_fix;
    logic [3:0]  w_syn;
    logic        w_par, w_dbl;
    logic [10:0] w_dec;
    logic [11:0] w_cat;
    logic [3:0]  w_in;
    logic [2:0]  w_nin, w_ncr;

    data_mem data_mem1 (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_wdata(w_wdata),
        .o_rdata(w_rdata)
    );

    assign ack  = r_ack;
    assign w_i2 = {2'b0, r_idx, 1'b0};

    // Hamming(16,11): parity at positions 1,2,4,8, overall parity in bit 0
    assign w_d   = {r_hi[2:0], r_lo};
    assign w_p8  = ^w_d[11:5];
    assign w_p4  = (^w_d[11:8]) ^ (^w_d[4:2]);
    assign w_p2  = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1];
    assign w_p1  = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1];
    assign w_p16 = (^w_d) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;
    assign w_enc = {w_d[11:5], w_p8, w_d[4:2], w_p4, w_d[1], w_p2, w_p1, w_p16};

    assign w_cw  = {r_hi, r_lo};
    assign w_dbl = !w_par && (w_syn != 4'd0);
    assign w_dec = {w_fix[15:9], w_fix[7:5], w_fix[3]};

    always_comb begin
        w_syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (w_cw[k]) w_syn = w_syn ^ 4'(k);
        end
        w_par = ^w_cw;
        w_fix = w_cw;
        if (w_par) w_fix[w_syn] = ~w_cw[w_syn];
    end

    // Crossing windows pair the previous byte's low nibble with this byte
    always_comb begin
        w_cat = {r_prev, w_rdata};
        w_in  = '0;
        w_nin = '0;
        w_ncr = '0;
        for (int s = 0; s < 4; s++) begin
            w_in[s] = (w_rdata[s +: 5] == r_pat);
            if (w_in[s]) w_nin = w_nin + 3'd1;
            if ((w_cat[s + 4 +: 5] == r_pat) && (r_idx != 5'd0))
                w_ncr = w_ncr + 3'd1;
        end
    end

    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = '0;
        case (r_state)
            S_E0: w_addr = w_i2;
            S_E1: w_addr = w_i2 + 8'd1;
            S_E2: begin
                w_addr = w_i2 + 8'd30; w_we = 1'b1; w_wdata = w_enc[7:0];
            end
            S_E3: begin
                w_addr = w_i2 + 8'd31; w_we = 1'b1; w_wdata = w_enc[15:8];
            end
            S_D0: w_addr = w_i2 + 8'd64;
            S_D1: w_addr = w_i2 + 8'd65;
            S_D2: begin
                w_addr = w_i2 + 8'd94; w_we = 1'b1; w_wdata = w_dec[7:0];
            end
            S_D3: begin
                w_addr  = w_i2 + 8'd95;
                w_we    = 1'b1;
                w_wdata = {w_dbl, 4'b0, w_dec[10:8]};
            end
            S_CP:  w_addr = 8'd160;
            S_CB:  w_addr = 8'd128 + {3'b0, r_idx};
            S_CW0: begin w_addr = 8'd192; w_we = 1'b1; w_wdata = r_c0; end
            S_CW1: begin w_addr = 8'd193; w_we = 1'b1; w_wdata = r_c1; end
            S_CW2: begin w_addr = 8'd194; w_we = 1'b1; w_wdata = r_c2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_prog  <= 2'd1;
            r_ack   <= 1'b0;
            r_idx   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_pat   <= '0;
            r_prev  <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req) begin
                    r_ack <= 1'b0;
                    r_idx <= '0;
                    case (r_prog)
                        2'd1:    r_state <= S_E0;
                        2'd2:    r_state <= S_D0;
                        default: begin
                            r_state <= S_CP;
                            r_c0    <= '0;
                            r_c1    <= '0;
                            r_c2    <= '0;
                            r_prev  <= '0;
                        end
                    endcase
                end
                S_E0: begin r_lo <= w_rdata; r_state <= S_E1; end
                S_E1: begin r_hi <= w_rdata; r_state <= S_E2; end
                S_E2: r_state <= S_E3;
                S_E3: begin
                    r_idx   <= r_idx + 5'd1;
                    r_state <= (r_idx == 5'd14) ? S_DONE : S_E0;
                end
                S_D0: begin r_lo <= w_rdata; r_state <= S_D1; end
                S_D1: begin r_hi <= w_rdata; r_state <= S_D2; end
                S_D2: r_state <= S_D3;
                S_D3: begin
                    r_idx   <= r_idx + 5'd1;
                    r_state <= (r_idx == 5'd14) ? S_DONE : S_D0;
                end
                S_CP: begin r_pat <= w_rdata[4:0]; r_state <= S_CB; end
                S_CB: begin
                    r_c0    <= r_c0 + {5'b0, w_nin};
                    r_c1    <= r_c1 + {7'b0, |w_in};
                    r_c2    <= r_c2 + {5'b0, w_nin} + {5'b0, w_ncr};
                    r_prev  <= w_rdata[3:0];
                    r_idx   <= r_idx + 5'd1;
                    r_state <= (r_idx == 5'd31) ? S_CW0 : S_CB;
                end
                S_CW0: r_state <= S_CW1;
                S_CW1: r_state <= S_CW2;
                S_CW2: r_state <= S_DONE;
                S_DONE: begin
                    r_ack   <= 1'b1;
                    r_prog  <= (r_prog == 2'd3) ? 2'd1 : r_prog + 2'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: encode, decode, pattern count,
// program rotation, busy-req rejection and mid-program reset.
module tb_top_level;
    logic clk = 1'b0;
    logic reset;
    logic req;
    logic ack;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    top_level dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .ack  (ack)
    );

    task automatic run_prog(input int busy_at, output int cyc,
                            output logic ack_after);
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
        ack_after = ack;
        cyc = 1;
        while (ack !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == busy_at) begin
                req = 1'b1;
                @(negedge clk) req = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 1'b0;
        for (int i = 0; i < 256; i++) dut.data_mem1.core[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_ack got=%b exp=0", ack);
        end
    endtask

    task automatic test_encode(input int busy_at);
        int cyc;
        logic a0;
        logic [15:0] got;
        logic [15:0] exp [3];
        exp[0] = 16'h0000; exp[1] = 16'h000F; exp[2] = 16'hFFFF;
        for (int i = 0; i < 30; i++) dut.data_mem1.core[i] = 8'h5A;
        dut.data_mem1.core[0] = 8'h00; dut.data_mem1.core[1] = 8'hF8;
        dut.data_mem1.core[2] = 8'h01; dut.data_mem1.core[3] = 8'h00;
        dut.data_mem1.core[4] = 8'hFF; dut.data_mem1.core[5] = 8'h07;
        for (int i = 30; i < 60; i++) dut.data_mem1.core[i] = 8'hCC;
        dut.data_mem1.core[60] = 8'hA5;
        run_prog(busy_at, cyc, a0);
        total++;
        if (a0 !== 1'b0) begin
            bad++;
            $display("FAIL enc_ack_clear got=%b exp=0", a0);
        end
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL enc_timeout ack=%b cycles=%0d limit=300", ack, cyc);
        end
        for (int s = 0; s < 3; s++) begin
            got = {dut.data_mem1.core[31 + 2 * s], dut.data_mem1.core[30 + 2 * s]};
            total++;
            if (got !== exp[s]) begin
                bad++;
                $display("FAIL enc_slot%0d got=%h exp=%h", s, got, exp[s]);
            end
        end
        total++;
        if (dut.data_mem1.core[60] !== 8'hA5) begin
            bad++;
            $display("FAIL enc_bound got=%h exp=a5", dut.data_mem1.core[60]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL enc_ack_hold got=%b exp=1", ack);
        end
    endtask

    task automatic test_decode(input bit dbl);
        int cyc;
        logic a0;
        logic [15:0] got;
        logic [15:0] vin [4];
        logic [15:0] exp [4];
        int n;
        vin[0] = 16'hFFDF; exp[0] = 16'h07FF;
        vin[1] = 16'h000E; exp[1] = 16'h0001;
        vin[2] = 16'h000F; exp[2] = 16'h0001;
        vin[3] = 16'hFDDF; exp[3] = 16'h87ED;
        if (dbl) begin
            vin[0] = 16'hFDDF; exp[0] = 16'h87ED;
        end
        n = dbl ? 1 : 4;
        for (int i = 64; i < 94; i++) dut.data_mem1.core[i] = 8'h00;
        for (int s = 0; s < n; s++) begin
            dut.data_mem1.core[64 + 2 * s] = vin[s][7:0];
            dut.data_mem1.core[65 + 2 * s] = vin[s][15:8];
        end
        for (int i = 94; i < 124; i++) dut.data_mem1.core[i] = 8'hCC;
        dut.data_mem1.core[124] = 8'hA5;
        run_prog(0, cyc, a0);
        total++;
        if (ack !== 1'b1 || a0 !== 1'b0) begin
            bad++;
            $display("FAIL dec_handshake ack=%b ack_after_req=%b cycles=%0d", ack, a0, cyc);
        end
        for (int s = 0; s < n; s++) begin
            got = {dut.data_mem1.core[95 + 2 * s], dut.data_mem1.core[94 + 2 * s]};
            total++;
            if (got !== exp[s]) begin
                bad++;
                $display("FAIL dec_slot%0d got=%h exp=%h", s, got, exp[s]);
            end
        end
        if (dbl) begin
            total++;
            if (dut.data_mem1.core[95][7] !== 1'b1) begin
                bad++;
                $display("FAIL dec_dbl_flag got=%b exp=1", dut.data_mem1.core[95][7]);
            end
        end
        total++;
        if (dut.data_mem1.core[124] !== 8'hA5) begin
            bad++;
            $display("FAIL dec_bound got=%h exp=a5", dut.data_mem1.core[124]);
        end
    endtask

    task automatic test_count(input string nm, input logic [7:0] pat,
                              input logic [7:0] fill, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2);
        int cyc;
        logic a0;
        logic [23:0] got;
        for (int i = 128; i < 160; i++) dut.data_mem1.core[i] = fill;
        dut.data_mem1.core[128] = b0;
        dut.data_mem1.core[129] = b1;
        dut.data_mem1.core[160] = pat;
        for (int i = 192; i < 196; i++) dut.data_mem1.core[i] = 8'hEE;
        run_prog(0, cyc, a0);
        total++;
        if (ack !== 1'b1 || a0 !== 1'b0) begin
            bad++;
            $display("FAIL cnt_%s_handshake ack=%b ack_after_req=%b", nm, ack, a0);
        end
        got = {dut.data_mem1.core[192], dut.data_mem1.core[193],
               dut.data_mem1.core[194]};
        total++;
        if (got !== {e0, e1, e2}) begin
            bad++;
            $display("FAIL cnt_%s got=%0d,%0d,%0d exp=%0d,%0d,%0d", nm,
                     got[23:16], got[15:8], got[7:0], e0, e1, e2);
        end
        total++;
        if (dut.data_mem1.core[195] !== 8'hEE) begin
            bad++;
            $display("FAIL cnt_%s_bound got=%h exp=ee", nm, dut.data_mem1.core[195]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_ack got=%b exp=0", ack);
        end
        test_encode(0);
    endtask

    initial begin
        test_reset();
        test_encode(5);
        test_decode(1'b0);
        test_count("zero", 8'h00, 8'h00, 8'h00, 8'h00, 8'd128, 8'd32, 8'd252);
        test_encode(0);
        test_decode(1'b1);
        test_count("ones", 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd0);
        test_encode(0);
        test_decode(1'b0);
        test_count("first", 8'h1F, 8'h00, 8'hF8, 8'h00, 8'd1, 8'd1, 8'd1);
        test_encode(0);
        test_decode(1'b1);
        test_count("cross", 8'h1F, 8'h00, 8'h03, 8'hE0, 8'd0, 8'd0, 8'd1);
        test_encode(0);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
